car_speed_regulator: RTL and testbench

- Downstream plant/actuator stage for control_unit_Self_driving: consumes its accelerate_car command and produces the car_speed value that feeds back into it.
- Integrates the accelerate/decelerate command into an 8-bit speed on a prescaled update tick.
- Applies a one-tick coast dead-time whenever the command drops, and saturates speed at 0 and MAX_SPEED.
- Used in closed-loop simulation and as the speed actuator model in the car controller top level.

---
 rtl/car_speed_regulator.sv | 123 ++++++++++++
 tb/tb_car_speed_regulator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/car_speed_regulator.sv
// car_speed_regulator: speed actuator/plant model for the self-driving controller.
// Integrates an accelerate/decelerate command into an 8-bit speed once per
// prescaled tick, inserts a one-tick coast when the command drops, and
// saturates the speed at 0 and MAX_SPEED.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-low reset
//   enable         engine on; 0 forces a release
//   accelerate_car acceleration request from the controller
//   car_speed      current speed (registered)
//   moving         car_speed != 0 (registered)
//   at_limit       car_speed == MAX_SPEED (registered)
//   brake_active   FSM in DECEL (registered)
//   state          FSM code: STOPPED=0, ACCEL=1, COAST=2, DECEL=3
module car_speed_regulator #(
  parameter int unsigned TICK_DIV   = 4,
  parameter int unsigned ACCEL_STEP = 2,
  parameter int unsigned DECEL_STEP = 3,
  parameter logic [7:0]  MAX_SPEED  = 8'd200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       accelerate_car,
  output logic [7:0] car_speed,
  output logic       moving,
  output logic       at_limit,
  output logic       brake_active,
  output logic [1:0] state
);

  localparam int unsigned SPEED_W = 8;
  localparam int unsigned ARITH_W = SPEED_W + 1;
  localparam int unsigned CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] STOPPED = 2'd0;
  localparam logic [1:0] ACCEL   = 2'd1;
  localparam logic [1:0] COAST   = 2'd2;
  localparam logic [1:0] DECEL   = 2'd3;

  logic [CNT_W-1:0]   cnt_q;
  logic               tick_c;
  logic               go_c;
  logic [ARITH_W-1:0] up_sum_c;
  logic [SPEED_W-1:0] up_c;
  logic [SPEED_W-1:0] dn_c;
  logic [1:0]         state_nx;
  logic [SPEED_W-1:0] speed_nx;

  // Free-running prescaler; wraps on the same edge that carries the tick.
  assign tick_c = (cnt_q == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign go_c = enable & accelerate_car;

  // Saturating step arithmetic, one bit wider than speed to catch overflow.
  assign up_sum_c = {1'b0, car_speed} + ARITH_W'(ACCEL_STEP);
  assign up_c     = (up_sum_c > {1'b0, MAX_SPEED}) ? MAX_SPEED : up_sum_c[SPEED_W-1:0];
  assign dn_c     = ({1'b0, car_speed} <= ARITH_W'(DECEL_STEP)) ? SPEED_W'(0)
                  : SPEED_W'({1'b0, car_speed} - ARITH_W'(DECEL_STEP));

  // Next state / speed; everything holds between ticks.
  always_comb begin
    state_nx = state;
    speed_nx = car_speed;
    if (tick_c) begin
      case (state)
        STOPPED: begin
          if (go_c) begin
            state_nx = ACCEL;
            speed_nx = up_c;
          end else begin
            speed_nx = '0;
          end
        end
        ACCEL: begin
          if (go_c) begin
            speed_nx = up_c;
          end else begin
            state_nx = COAST;
          end
        end
        COAST, DECEL: begin
          if (go_c) begin
            state_nx = ACCEL;
            speed_nx = up_c;
          end else begin
            speed_nx = dn_c;
            state_nx = (dn_c == '0) ? STOPPED : DECEL;
          end
        end
      endcase
    end
  end

  // State, speed and status flags all update on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= STOPPED;
      car_speed    <= '0;
      moving       <= 1'b0;
      at_limit     <= 1'b0;
      brake_active <= 1'b0;
    end else begin
      state        <= state_nx;
      car_speed    <= speed_nx;
      moving       <= (speed_nx != '0);
      at_limit     <= (speed_nx == MAX_SPEED);
      brake_active <= (state_nx == DECEL);
    end
  end

endmodule

// File: tb/tb_car_speed_regulator.sv
// Bench for car_speed_regulator: directed scenarios with literal expectations,
// then randomized command/enable/reset stimulus, all compared every cycle
// against an arithmetic model of the speed rules.
module tb_car_speed_regulator;

  localparam int TICK_DIV   = 4;
  localparam int ACCEL_STEP = 2;
  localparam int DECEL_STEP = 3;
  localparam int MAX_SPEED  = 200;

  localparam int M_STOPPED = 0;
  localparam int M_ACCEL   = 1;
  localparam int M_COAST   = 2;
  localparam int M_DECEL   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       accelerate_car;
  logic [7:0] car_speed;
  logic       moving;
  logic       at_limit;
  logic       brake_active;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  int m_cnt   = 0;
  int m_speed = 0;
  int m_mode  = M_STOPPED;

  car_speed_regulator #(
    .TICK_DIV  (TICK_DIV),
    .ACCEL_STEP(ACCEL_STEP),
    .DECEL_STEP(DECEL_STEP),
    .MAX_SPEED (8'(MAX_SPEED))
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .accelerate_car(accelerate_car),
    .car_speed     (car_speed),
    .moving        (moving),
    .at_limit      (at_limit),
    .brake_active  (brake_active),
    .state         (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Speed rules in plain integer arithmetic.
  function automatic int speed_up(input int s);
    return (s + ACCEL_STEP > MAX_SPEED) ? MAX_SPEED : s + ACCEL_STEP;
  endfunction

  function automatic int speed_dn(input int s);
    return (s <= DECEL_STEP) ? 0 : s - DECEL_STEP;
  endfunction

  function automatic int next_speed(input int mode, input int s, input bit go);
    if (go) return speed_up(s);
    if (mode == M_ACCEL) return s;
    if (mode == M_STOPPED) return 0;
    return speed_dn(s);
  endfunction

  function automatic int next_mode(input int mode, input int s, input bit go);
    if (go) return M_ACCEL;
    if (mode == M_ACCEL) return M_COAST;
    if (mode == M_STOPPED) return M_STOPPED;
    return (speed_dn(s) == 0) ? M_STOPPED : M_DECEL;
  endfunction

  // Reference model: updates only on every TICK_DIV-th edge after reset.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt   <= 0;
      m_speed <= 0;
      m_mode  <= M_STOPPED;
    end else begin
      m_cnt <= (m_cnt == TICK_DIV - 1) ? 0 : m_cnt + 1;
      if (m_cnt == TICK_DIV - 1) begin
        m_speed <= next_speed(m_mode, m_speed, enable && accelerate_car);
        m_mode  <= next_mode(m_mode, m_speed, enable && accelerate_car);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("cyc_speed", int'(car_speed), m_speed);
    chk("cyc_state", int'(state), m_mode);
    chk("cyc_moving", int'(moving), int'(m_speed != 0));
    chk("cyc_at_limit", int'(at_limit), int'(m_speed == MAX_SPEED));
    chk("cyc_brake", int'(brake_active), int'(m_mode == M_DECEL));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    enable = 1'b0;
    accelerate_car = 1'b0;
    cyc(3);
    chk("rst_speed", int'(car_speed), 0);
    chk("rst_state", int'(state), M_STOPPED);
    rst = 1'b1;

    // Idle with go low.
    cyc(20);
    chk("idle_speed", int'(car_speed), 0);
    chk("idle_state", int'(state), M_STOPPED);

    // Accelerate from stop: only every 4th edge changes speed.
    enable = 1'b1;
    accelerate_car = 1'b1;
    cyc(3);
    chk("no_early_tick", int'(car_speed), 0);
    cyc(1);
    chk("first_tick", int'(car_speed), 2);
    cyc(16);
    chk("accel_speed10", int'(car_speed), 10);
    chk("accel_state", int'(state), M_ACCEL);
    chk("accel_moving", int'(moving), 1);

    // Release: coast, then decel 7,4,1,0.
    accelerate_car = 1'b0;
    cyc(4);
    chk("coast_state", int'(state), M_COAST);
    chk("coast_speed", int'(car_speed), 10);
    chk("coast_brake", int'(brake_active), 0);
    cyc(4);
    chk("decel7", int'(car_speed), 7);
    chk("decel_brake", int'(brake_active), 1);
    cyc(4);
    chk("decel4", int'(car_speed), 4);
    cyc(4);
    chk("decel1", int'(car_speed), 1);
    cyc(4);
    chk("stop_speed", int'(car_speed), 0);
    chk("stop_state", int'(state), M_STOPPED);
    chk("stop_moving", int'(moving), 0);

    // Re-acceleration from DECEL skips the coast.
    accelerate_car = 1'b1;
    cyc(20);
    chk("reacc_10", int'(car_speed), 10);
    accelerate_car = 1'b0;
    cyc(8);
    chk("reacc_decel7", int'(car_speed), 7);
    accelerate_car = 1'b1;
    cyc(4);
    chk("reacc_state", int'(state), M_ACCEL);
    chk("reacc_9", int'(car_speed), 9);

    // Saturation at MAX_SPEED.
    cyc(4 * 105);
    chk("sat_speed", int'(car_speed), 200);
    chk("sat_limit", int'(at_limit), 1);
    chk("sat_state", int'(state), M_ACCEL);

    // Enable low overrides a held accelerate request.
    enable = 1'b0;
    cyc(4);
    chk("en_coast_state", int'(state), M_COAST);
    chk("en_coast_speed", int'(car_speed), 200);
    cyc(4);
    chk("en_decel_state", int'(state), M_DECEL);
    chk("en_decel_speed", int'(car_speed), 197);
    chk("en_decel_limit", int'(at_limit), 0);

    // Decelerate to a stop, then a one-cycle glitch between ticks.
    enable = 1'b1;
    accelerate_car = 1'b0;
    cyc(4 * 70);
    chk("full_stop", int'(car_speed), 0);
    cyc(1);
    accelerate_car = 1'b1;
    cyc(1);
    accelerate_car = 1'b0;
    cyc(2);
    chk("glitch_speed", int'(car_speed), 0);
    chk("glitch_state", int'(state), M_STOPPED);

    // Mid-cycle reset while accelerating at 6.
    accelerate_car = 1'b1;
    cyc(12);
    chk("pre_rst_speed", int'(car_speed), 6);
    #2 rst = 1'b0;
    #1;
    chk("async_speed", int'(car_speed), 0);
    chk("async_state", int'(state), M_STOPPED);
    chk("async_moving", int'(moving), 0);
    chk("async_flags", int'({at_limit, brake_active}), 0);
    @(negedge clk);
    rst = 1'b1;
    cyc(3);
    chk("post_rst_wait", int'(car_speed), 0);
    cyc(1);
    chk("post_rst_tick", int'(car_speed), 2);

    // Randomized run: sticky commands, occasional enable drops and resets.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) accelerate_car = ~accelerate_car;
      if ($urandom_range(0, 31) == 0) enable = ~enable;
      if ($urandom_range(0, 599) == 0) begin
        #3 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end
    end
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
